// File: rtl/vsmac_act_stage_pkg.sv
// Shared constants and helpers for the MAC activation stage.
//   - default lane count, lane width and accumulation count
//   - accumulation counter width, FIFO depth and FIFO count type
//   - lane saturation limits, available as defaults and as width-driven helpers
package vsmac_act_stage_pkg;

  localparam int SIZE_DEF          = 6;
  localparam int WIDTH_DEF         = 8;
  localparam int ACCUMULATIONS_DEF = 3;
  localparam int ACC_CNT_W         = $clog2(ACCUMULATIONS_DEF);

  localparam int FIFO_DEPTH = 2;
  typedef logic [$clog2(FIFO_DEPTH + 1)-1:0] fifo_cnt_t;

  localparam int LANE_MAX_DEF = (32'sd1 <<< (WIDTH_DEF - 1)) - 32'sd1;
  localparam int LANE_MIN_DEF = -(32'sd1 <<< (WIDTH_DEF - 1));

  // Counter width that still works when a single enable completes a vector
  function automatic int cnt_width(input int accs);
    return (accs > 1) ? $clog2(accs) : 1;
  endfunction

  function automatic int lane_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic int lane_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/vsmac_act_stage_if.sv
// Result stream from the activation stage toward the next layer.
//   out_data  : head vector, lane i = [WIDTH*i +: WIDTH]
//   out_valid : a vector is available
//   out_ready : consumer takes the head when out_valid && out_ready
// master = activation stage, slave = consumer.
interface vsmac_act_stage_if #(
  parameter int SIZE  = 6,
  parameter int WIDTH = 8
);
  logic [SIZE*WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/vsmac_act_stage_act_lane.sv
// One lane of activation math, purely combinational.
//   mac  : signed MAC result for this lane
//   bias : signed bias for this lane
//   res  : sext(mac)+sext(bias), arithmetic shift right by SHIFT, then clamped
//          to [0, max] when RELU=1 or to [min, max] when RELU=0
module act_lane
  import vsmac_act_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHIFT = 0,
  parameter int RELU  = 1
) (
  input  logic [WIDTH-1:0] mac,
  input  logic [WIDTH-1:0] bias,
  output logic [WIDTH-1:0] res
);

  localparam int MAX_I = lane_max(WIDTH);
  localparam int MIN_I = (RELU != 0) ? 0 : lane_min(WIDTH);
  localparam logic signed [WIDTH:0] SAT_MAX = (WIDTH + 1)'(MAX_I);
  localparam logic signed [WIDTH:0] SAT_MIN = (WIDTH + 1)'(MIN_I);

  logic signed [WIDTH:0] sum_s;
  logic signed [WIDTH:0] sh_s;

  // One extra bit keeps the bias add exact before saturation
  assign sum_s = $signed({mac[WIDTH-1], mac}) + $signed({bias[WIDTH-1], bias});
  assign sh_s  = sum_s >>> SHIFT;

  // Saturate the shifted sum into the lane range
  always_comb begin
    if (sh_s > SAT_MAX) begin
      res = SAT_MAX[WIDTH-1:0];
    end else if (sh_s < SAT_MIN) begin
      res = SAT_MIN[WIDTH-1:0];
    end else begin
      res = sh_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/vsmac_act_stage.sv
// Activation stage behind the vector-scalar MAC array.
//   clk, reset : clock and synchronous active-low reset
//   enable     : MAC enable; every ACCUMULATIONS enables complete one vector
//   mac_out    : MAC result vector, sampled one cycle after the final enable
//   bias       : per-lane bias, sampled together with mac_out
//   full       : result FIFO holds two vectors
//   overflow   : sticky, a finished vector was dropped on a full FIFO
//   out        : valid/ready stream of finished vectors (head of the FIFO)
module vsmac_act_stage
  import vsmac_act_stage_pkg::*;
#(
  parameter int SIZE          = SIZE_DEF,
  parameter int WIDTH         = WIDTH_DEF,
  parameter int ACCUMULATIONS = ACCUMULATIONS_DEF,
  parameter int SHIFT         = 0,
  parameter int RELU          = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WIDTH*SIZE-1:0] mac_out,
  input  logic [WIDTH*SIZE-1:0] bias,
  output logic                  full,
  output logic                  overflow,
  vsmac_act_stage_if.master     out
);

  localparam int VEC_W = WIDTH * SIZE;
  localparam int CNT_W = cnt_width(ACCUMULATIONS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ACCUMULATIONS - 1);
  localparam fifo_cnt_t        CNT_FULL  = fifo_cnt_t'(FIFO_DEPTH);

  logic [CNT_W-1:0] acc_cnt_r;
  logic             cap_pend_r;
  logic [VEC_W-1:0] res_s;

  logic [VEC_W-1:0] mem_r [FIFO_DEPTH];
  logic             wr_ptr_r, rd_ptr_r;
  fifo_cnt_t        count_r;
  logic             valid_r, full_r, ovf_r;
  logic [VEC_W-1:0] head_r;

  logic             push_s, pop_s, wr_en_s;
  logic             wr_ptr_n, rd_ptr_n;
  fifo_cnt_t        count_n;
  logic             ovf_n;
  logic [VEC_W-1:0] head_n;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    act_lane #(.WIDTH(WIDTH), .SHIFT(SHIFT), .RELU(RELU)) u_lane (
      .mac  (mac_out[WIDTH*i +: WIDTH]),
      .bias (bias[WIDTH*i +: WIDTH]),
      .res  (res_s[WIDTH*i +: WIDTH])
    );
  end

  // Enable counter; flags a capture for the cycle after the last enable of a vector
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_cnt_r  <= '0;
      cap_pend_r <= 1'b0;
    end else if (enable) begin
      if (acc_cnt_r == CNT_LAST) begin
        acc_cnt_r  <= '0;
        cap_pend_r <= 1'b1;
      end else begin
        acc_cnt_r  <= acc_cnt_r + CNT_W'(1);
        cap_pend_r <= 1'b0;
      end
    end else begin
      cap_pend_r <= 1'b0;
    end
  end

  assign push_s = cap_pend_r;
  assign pop_s  = valid_r & out.out_ready;

  // FIFO next state; a push on a full FIFO still lands when the head leaves that cycle
  always_comb begin
    wr_en_s  = 1'b0;
    wr_ptr_n = wr_ptr_r;
    rd_ptr_n = rd_ptr_r;
    count_n  = count_r;
    ovf_n    = ovf_r;
    case ({push_s, pop_s})
      2'b11: begin
        wr_en_s  = 1'b1;
        wr_ptr_n = ~wr_ptr_r;
        rd_ptr_n = ~rd_ptr_r;
      end
      2'b10: begin
        if (count_r == CNT_FULL) begin
          ovf_n = 1'b1;
        end else begin
          wr_en_s  = 1'b1;
          wr_ptr_n = ~wr_ptr_r;
          count_n  = count_r + fifo_cnt_t'(1);
        end
      end
      2'b01: begin
        rd_ptr_n = ~rd_ptr_r;
        count_n  = count_r - fifo_cnt_t'(1);
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Next head: the vector being written if it lands in the head slot, else storage
  always_comb begin
    if (wr_en_s && (wr_ptr_r == rd_ptr_n)) begin
      head_n = res_s;
    end else begin
      head_n = mem_r[rd_ptr_n];
    end
  end

  // FIFO storage, pointers and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
      head_r   <= '0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= res_s;
      end
      wr_ptr_r <= wr_ptr_n;
      rd_ptr_r <= rd_ptr_n;
      count_r  <= count_n;
      valid_r  <= (count_n != '0);
      full_r   <= (count_n == CNT_FULL);
      ovf_r    <= ovf_n;
      head_r   <= head_n;
    end
  end

  assign out.out_data  = head_r;
  assign out.out_valid = valid_r;
  assign full          = full_r;
  assign overflow      = ovf_r;

endmodule
